baud_gen: RTL



---
 rtl/baud_gen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/baud_gen.sv
// ---------------------------------------------------------------------------
// baud_gen
//
// Programmable baud-rate generator for the SPART serial port. The processor
// writes a 16-bit divisor over the 8-bit I/O bus. The low byte is staged
// first. Writing the high byte commits both bytes at once. The block then
// produces single-cycle 16x-oversample ticks for the transmitter and the
// receiver, plus a once-per-bit enable on every 16th tick.
//
// Parameters:
//   DEFAULT_DIV   divisor loaded at reset (162 = 19200 baud at 50 MHz, 16x)
//
// Ports:
//   i_clk         system clock, rising-edge active
//   i_rst         asynchronous, active-high reset
//   i_iocs        chip select for SPART I/O space
//   i_iorw        1 = read, 0 = write
//   i_ioaddr      register select; 2'b10 = DB_LOW, 2'b11 = DB_HIGH
//   i_db_in       write data from the processor bus
//   o_db_out      registered read data (active divisor bytes, else 0)
//   o_rd_hit      registered; high when o_db_out carries data from here
//   o_brg_tx_en   registered 16x tick to the transmitter
//   o_brg_rx_en   registered 16x tick to the receiver (same timing as tx)
//   o_brg_bit_en  registered; high on every 16th tick (bit boundary)
// ---------------------------------------------------------------------------
module baud_gen #(
    parameter logic [15:0] DEFAULT_DIV = 16'd162
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_iocs,
    input  logic       i_iorw,
    input  logic [1:0] i_ioaddr,
    input  logic [7:0] i_db_in,
    output logic [7:0] o_db_out,
    output logic       o_rd_hit,
    output logic       o_brg_tx_en,
    output logic       o_brg_rx_en,
    output logic       o_brg_bit_en
);

    logic [15:0] r_div;
    logic [7:0]  r_lo_stage;
    logic [15:0] r_cnt;
    logic [3:0]  r_sub;

    logic [7:0]  r_db_out;
    logic        r_rd_hit;
    logic        r_tx_en;
    logic        r_rx_en;
    logic        r_bit_en;

    logic        w_wr_lo;
    logic        w_wr_hi;
    logic        w_rd;
    logic        w_tick;

    // Bus decode. Only the two upper addresses belong to this block. A read
    // of either of them is a hit.
    assign w_wr_lo = i_iocs && !i_iorw && (i_ioaddr == 2'b10);
    assign w_wr_hi = i_iocs && !i_iorw && (i_ioaddr == 2'b11);
    assign w_rd    = i_iocs &&  i_iorw && i_ioaddr[1];

    // A tick fires when the down-counter has run out. A commit in the same
    // cycle takes priority and swallows the tick, so the new divisor always
    // starts from a clean phase.
    assign w_tick  = (r_cnt == 16'd0) && !w_wr_hi;

    // Divisor registers. The low byte waits in a staging register, so a
    // lone DB_LOW write never changes the running rate. The DB_HIGH write
    // commits both halves together.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div      <= DEFAULT_DIV;
            r_lo_stage <= DEFAULT_DIV[7:0];
        end else begin
            if (w_wr_lo) begin
                r_lo_stage <= i_db_in;
            end
            if (w_wr_hi) begin
                r_div <= {i_db_in, r_lo_stage};
            end
        end
    end

    // Tick timing. The down-counter reloads with the divisor after reaching
    // zero, which gives a period of div+1 cycles. The 4-bit sub-counter
    // counts ticks so that every 16th tick marks a bit boundary. A commit
    // reloads the counter straight from the bus value, because r_div is not
    // updated yet in that cycle. It also restarts the sub-counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= DEFAULT_DIV;
            r_sub <= 4'd0;
        end else if (w_wr_hi) begin
            r_cnt <= {i_db_in, r_lo_stage};
            r_sub <= 4'd0;
        end else if (r_cnt == 16'd0) begin
            r_cnt <= r_div;
            r_sub <= r_sub + 4'd1;
        end else begin
            r_cnt <= r_cnt - 16'd1;
        end
    end

    // Output registers. Every output is a flop, so there is no
    // combinational path from the bus to the outputs. Reads return the
    // active divisor, never the staged byte. The bit enable lines up with
    // the tick on which the sub-counter wraps.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_db_out <= 8'h00;
            r_rd_hit <= 1'b0;
            r_tx_en  <= 1'b0;
            r_rx_en  <= 1'b0;
            r_bit_en <= 1'b0;
        end else begin
            r_rd_hit <= w_rd;
            if (w_rd) begin
                r_db_out <= i_ioaddr[0] ? r_div[15:8] : r_div[7:0];
            end else begin
                r_db_out <= 8'h00;
            end
            r_tx_en  <= w_tick;
            r_rx_en  <= w_tick;
            r_bit_en <= w_tick && (r_sub == 4'd15);
        end
    end

    assign o_db_out     = r_db_out;
    assign o_rd_hit     = r_rd_hit;
    assign o_brg_tx_en  = r_tx_en;
    assign o_brg_rx_en  = r_rx_en;
    assign o_brg_bit_en = r_bit_en;

endmodule
